// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage hazard inputs and EX-stage forwarding/stall controls between the pipeline and the
// hazard/forwarding controller.
interface hazard_forward_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_we;
    logic             id_is_load;
    logic             mem_busy;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall_if_id;
    logic             bubble_ex;
    logic             hold_all;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_we, id_is_load,
        output mem_busy,
        input  fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex, hold_all, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_we, id_is_load,
        input  mem_busy,
        output fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex, hold_all, stall_count
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// EX-stage forwarding selects, load-use stall/bubble and memory-busy freeze for a 5-stage
// pipeline, driven from a private shadow copy of the EX/MEM/WB destinations.
module hazard_forward_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    hazard_forward_ctrl_if.slave bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state_q, state_d;

    // Shadow pipeline; source registers are only needed in EX.
    logic             ex_valid_q, ex_we_q, ex_load_q;
    logic [REG_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic             mem_valid_q, mem_we_q, mem_load_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             wb_valid_q, wb_we_q, wb_load_q;
    logic [REG_W-1:0] wb_rd_q;

    logic [CNT_W-1:0] stall_count_q;

    logic       lu;
    logic       busy;
    logic       hold_all;
    logic       stall_if_id;
    logic       bubble_ex;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             m_valid,
        input logic             m_we,
        input logic             m_load,
        input logic [REG_W-1:0] m_rd,
        input logic             w_valid,
        input logic             w_we,
        input logic [REG_W-1:0] w_rd
    );
        // Load data is not ready in MEM; that case is covered by the load-use stall.
        if (m_valid && m_we && !m_load && (m_rd != '0) && (m_rd == rs)) begin
            return 2'b01;
        end
        if (w_valid && w_we && (w_rd != '0) && (w_rd == rs)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_valid_q) begin
            fwd_a_sel = fwd_sel(ex_rs1_q, mem_valid_q, mem_we_q, mem_load_q, mem_rd_q,
                                wb_valid_q, wb_we_q, wb_rd_q);
            fwd_b_sel = fwd_sel(ex_rs2_q, mem_valid_q, mem_we_q, mem_load_q, mem_rd_q,
                                wb_valid_q, wb_we_q, wb_rd_q);
        end
    end

    always_comb begin
        lu = ex_valid_q && ex_load_q && ex_we_q && (ex_rd_q != '0) && bus.id_valid &&
             ((bus.id_use_rs1 && (bus.id_rs1 == ex_rd_q)) ||
              (bus.id_use_rs2 && (bus.id_rs2 == ex_rd_q)));
    end

    // Gated so every control output reads zero while reset is held, even with mem_busy high.
    assign busy = bus.mem_busy & reset_n;

    always_comb begin
        state_d     = state_q;
        hold_all    = 1'b0;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        case (state_q)
            RUN: begin
                if (busy) begin
                    // Freeze wins over a coincident load-use; it is re-detected after HOLD.
                    hold_all = 1'b1;
                    state_d  = HOLD;
                end else begin
                    stall_if_id = lu;
                    bubble_ex   = lu;
                end
            end
            HOLD: begin
                hold_all    = 1'b1;
                stall_if_id = 1'b1;
                if (!bus.mem_busy) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_load_q   <= 1'b0;
            wb_rd_q     <= '0;
        end else if (!hold_all) begin
            ex_valid_q  <= bus.id_valid & ~bubble_ex;
            ex_we_q     <= bus.id_reg_we;
            ex_load_q   <= bus.id_is_load;
            ex_rs1_q    <= bus.id_rs1;
            ex_rs2_q    <= bus.id_rs2;
            ex_rd_q     <= bus.id_rd;
            mem_valid_q <= ex_valid_q;
            mem_we_q    <= ex_we_q;
            mem_load_q  <= ex_load_q;
            mem_rd_q    <= ex_rd_q;
            wb_valid_q  <= mem_valid_q;
            wb_we_q     <= mem_we_q;
            wb_load_q   <= mem_load_q;
            wb_rd_q     <= mem_rd_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
        end else if (stall_if_id && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign bus.fwd_a_sel   = fwd_a_sel;
    assign bus.fwd_b_sel   = fwd_b_sel;
    assign bus.stall_if_id = stall_if_id;
    assign bus.bubble_ex   = bubble_ex;
    assign bus.hold_all    = hold_all;
    assign bus.stall_count = stall_count_q;

    // WB load flag is carried for completeness of the shadow entry; forwarding from WB ignores it.
    logic unused_wb_load;
    assign unused_wb_load = wb_load_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, load-use, mem_busy freeze, counter
// saturation (second instance with a 2-bit counter) and asynchronous reset.
module tb_hazard_forward_ctrl;
    logic clock = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    hazard_forward_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
    hazard_forward_ctrl_if #(.REG_W(5), .CNT_W(2))  bus_sat ();

    assign bus_sat.id_valid   = bus.id_valid;
    assign bus_sat.id_rs1     = bus.id_rs1;
    assign bus_sat.id_rs2     = bus.id_rs2;
    assign bus_sat.id_use_rs1 = bus.id_use_rs1;
    assign bus_sat.id_use_rs2 = bus.id_use_rs2;
    assign bus_sat.id_rd      = bus.id_rd;
    assign bus_sat.id_reg_we  = bus.id_reg_we;
    assign bus_sat.id_is_load = bus.id_is_load;
    assign bus_sat.mem_busy   = bus.mem_busy;

    hazard_forward_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    hazard_forward_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_sat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld);
        bus.id_valid   = v;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
        bus.id_rd      = rd;
        bus.id_reg_we  = we;
        bus.id_is_load = ld;
        #1;
    endtask

    task automatic set_busy(input logic b);
        bus.mem_busy = b;
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.mem_busy = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        #9;
        chk("rst_fwd_a", 32'(bus.fwd_a_sel), 0);
        chk("rst_fwd_b", 32'(bus.fwd_b_sel), 0);
        chk("rst_stall", 32'(bus.stall_if_id), 0);
        chk("rst_bubble", 32'(bus.bubble_ex), 0);
        chk("rst_hold", 32'(bus.hold_all), 0);
        chk("rst_count", 32'(bus.stall_count), 0);
        reset_n = 1'b1;

        // T1: back-to-back dependency forwards from MEM, one gap forwards from WB
        issue(1, 1, 0, 1, 0, 5, 1, 0);
        tick();
        issue(1, 5, 1, 1, 1, 6, 1, 0);
        tick();
        chk("t1_mem_a", 32'(bus.fwd_a_sel), 1);
        chk("t1_mem_b", 32'(bus.fwd_b_sel), 0);
        issue(1, 0, 0, 1, 0, 9, 1, 0);
        tick();
        issue(1, 2, 0, 1, 0, 10, 1, 0);
        tick();
        issue(1, 9, 0, 1, 1, 11, 1, 0);
        tick();
        chk("t1_wb_a", 32'(bus.fwd_a_sel), 2);
        chk("t1_wb_b", 32'(bus.fwd_b_sel), 0);
        chk("t1_no_stall", 32'(bus.stall_if_id), 0);

        // T2: lw x7 ; add x8,x7,x7
        issue(1, 2, 0, 1, 0, 7, 1, 1);
        tick();
        issue(1, 7, 7, 1, 1, 8, 1, 0);
        chk("t2_stall", 32'(bus.stall_if_id), 1);
        chk("t2_bubble", 32'(bus.bubble_ex), 1);
        chk("t2_hold", 32'(bus.hold_all), 0);
        tick();
        chk("t2_stall_once", 32'(bus.stall_if_id), 0);
        chk("t2_bubble_once", 32'(bus.bubble_ex), 0);
        chk("t2_bubble_fwd_a", 32'(bus.fwd_a_sel), 0);
        tick();
        chk("t2_wb_a", 32'(bus.fwd_a_sel), 2);
        chk("t2_wb_b", 32'(bus.fwd_b_sel), 2);
        chk("t2_count", 32'(bus.stall_count), 1);
        chk("t2_count_sat", 32'(bus_sat.stall_count), 1);

        // T3: lw x0 causes no stall; x0 writers in MEM and WB never forward
        issue(1, 0, 0, 1, 0, 0, 1, 1);
        tick();
        issue(1, 0, 0, 1, 0, 0, 1, 0);
        chk("t3_no_lu_x0", 32'(bus.stall_if_id), 0);
        tick();
        issue(1, 0, 0, 1, 1, 12, 1, 0);
        tick();
        chk("t3_x0_a", 32'(bus.fwd_a_sel), 0);
        chk("t3_x0_b", 32'(bus.fwd_b_sel), 0);

        // T4: MEM and WB both write x3; MEM wins
        issue(1, 1, 0, 1, 0, 3, 1, 0);
        tick();
        issue(1, 1, 0, 1, 0, 3, 1, 0);
        tick();
        issue(1, 4, 3, 1, 1, 13, 1, 0);
        tick();
        chk("t4_prio_b", 32'(bus.fwd_b_sel), 1);
        chk("t4_prio_a", 32'(bus.fwd_a_sel), 0);
        issue(0, 3, 3, 1, 1, 0, 0, 0);
        tick();
        chk("t4_ex_invalid_b", 32'(bus.fwd_b_sel), 0);

        // T5: mem_busy for 4 cycles over a load-use pair
        reset_n = 1'b0;
        #1;
        chk("t5_reset_count", 32'(bus.stall_count), 0);
        reset_n = 1'b1;
        #1;
        issue(1, 2, 0, 1, 0, 14, 1, 1);
        tick();
        issue(1, 14, 0, 1, 0, 15, 1, 0);
        set_busy(1);
        chk("t5_c0_hold", 32'(bus.hold_all), 1);
        chk("t5_c0_stall", 32'(bus.stall_if_id), 0);
        chk("t5_c0_bubble", 32'(bus.bubble_ex), 0);
        tick();
        chk("t5_c1_hold", 32'(bus.hold_all), 1);
        chk("t5_c1_stall", 32'(bus.stall_if_id), 1);
        chk("t5_c1_bubble", 32'(bus.bubble_ex), 0);
        tick();
        tick();
        chk("t5_c3_hold", 32'(bus.hold_all), 1);
        tick();
        set_busy(0);
        chk("t5_c4_hold", 32'(bus.hold_all), 1);
        chk("t5_c4_stall", 32'(bus.stall_if_id), 1);
        tick();
        chk("t5_c5_hold", 32'(bus.hold_all), 0);
        chk("t5_c5_stall", 32'(bus.stall_if_id), 1);
        chk("t5_c5_bubble", 32'(bus.bubble_ex), 1);
        chk("t5_c5_count", 32'(bus.stall_count), 4);
        tick();
        chk("t5_c6_stall", 32'(bus.stall_if_id), 0);
        chk("t5_count", 32'(bus.stall_count), 5);
        chk("t6_count_sat", 32'(bus_sat.stall_count), 3);

        // T6: asynchronous reset during HOLD, then during a load-use stall
        set_busy(1);
        tick();
        chk("t6_hold_before", 32'(bus.hold_all), 1);
        chk("t6_stall_before", 32'(bus.stall_if_id), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_hold", 32'(bus.hold_all), 0);
        chk("t6_rst_stall", 32'(bus.stall_if_id), 0);
        chk("t6_rst_bubble", 32'(bus.bubble_ex), 0);
        chk("t6_rst_fwd_a", 32'(bus.fwd_a_sel), 0);
        chk("t6_rst_count", 32'(bus.stall_count), 0);
        chk("t6_rst_count_sat", 32'(bus_sat.stall_count), 0);
        set_busy(0);
        reset_n = 1'b1;
        #1;
        issue(1, 2, 0, 1, 0, 14, 1, 1);
        tick();
        issue(1, 14, 0, 1, 0, 15, 1, 0);
        chk("t6_lu_stall", 32'(bus.stall_if_id), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_lu_bubble", 32'(bus.bubble_ex), 0);
        chk("t6_rst_lu_stall", 32'(bus.stall_if_id), 0);
        reset_n = 1'b1;
        tick();
        chk("t6_no_pending", 32'(bus.bubble_ex), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
